// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter
// Shares one serial transmitter between two byte producers: requester A
// (keyboard ASCII) and requester B (receiver echo). Each requester owns a
// small FIFO. A round-robin scheduler pops one byte at a time, strobes the
// transmitter and follows its busy handshake. A short idle gap follows every
// frame.
//
// Ports
//   clk, rst_n        module clock (posedge), async active-low reset
//   wr_a/din_a        push strobe and byte, requester A
//   wr_b/din_b        push strobe and byte, requester B
//   clr_ovf           synchronous clear of ovf_a, ovf_b, ack_err
//   tx_busy           transmitter busy, high for the length of a frame
//   tx_start          one-cycle start strobe to the transmitter
//   tx_data, tx_src   byte being sent and its source (0=A, 1=B)
//   cnt_a, cnt_b      FIFO occupancy
//   ovf_a, ovf_b      sticky: a push to a full FIFO was dropped
//   ack_err           sticky: tx_busy did not rise within ACK_TIMEOUT
//   idle              scheduler idle and both FIFOs empty
//
// State table
//   state       | meaning
//   S_IDLE      | waiting for a byte; grants and pops on the cycle it leaves
//   S_START     | tx_start high for this cycle; loads the ack timer
//   S_WAIT_ACK  | waiting for tx_busy to rise; abandons the byte on timeout
//   S_WAIT_DONE | frame in progress; leaves when tx_busy falls
//   S_GAP       | inter-frame idle gap

module serial_tx_arbiter_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic [7:0]                 din_i,
   input  logic                       pop_i,
   output logic [7:0]                 head_o,
   output logic [$clog2(DEPTH):0]     cnt_o,
   output logic [$clog2(DEPTH):0]     cnt_nxt_o,
   output logic                       drop_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pop_ok, push_ok;

   assign pop_ok  = pop_i && (cnt_q != '0);
   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   assign push_ok = push_i && ((cnt_q != CNT_FULL) || pop_ok);
   assign drop_o  = push_i && !push_ok;

   always_comb begin
      cnt_d = cnt_q;
      if (push_ok && !pop_ok)
         cnt_d = cnt_q + CNT_ONE;
      else if (!push_ok && pop_ok)
         cnt_d = cnt_q - CNT_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         cnt_q <= cnt_d;
      end
   end

   // storage is not reset: occupancy and pointers define what is valid
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
   end

   assign head_o    = mem_q[rd_ptr_q];
   assign cnt_o     = cnt_q;
   assign cnt_nxt_o = cnt_d;
endmodule

module serial_tx_arbiter #(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned GAP_CYCLES  = 2,
   parameter int unsigned ACK_TIMEOUT = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_a,
   input  logic [7:0]             din_a,
   input  logic                   wr_b,
   input  logic [7:0]             din_b,
   input  logic                   clr_ovf,
   input  logic                   tx_busy,
   output logic                   tx_start,
   output logic [7:0]             tx_data,
   output logic                   tx_src,
   output logic [$clog2(DEPTH):0] cnt_a,
   output logic [$clog2(DEPTH):0] cnt_b,
   output logic                   ovf_a,
   output logic                   ovf_b,
   output logic                   ack_err,
   output logic                   idle
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int unsigned TMAX = (ACK_TIMEOUT > GAP_CYCLES) ?
                                  ((ACK_TIMEOUT > 1) ? ACK_TIMEOUT : 1) :
                                  ((GAP_CYCLES > 1) ? GAP_CYCLES : 1);
   localparam int TW = $clog2(TMAX + 1);
   localparam logic [TW-1:0] TMR_ONE  = TW'(1);
   localparam logic [TW-1:0] ACK_LOAD = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
   // GAP_CYCLES=0 still spends the single cycle of the GAP state
   localparam logic [TW-1:0] GAP_LOAD = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_WAIT_ACK, S_WAIT_DONE, S_GAP
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          last_b_q, last_b_d;
   logic          tx_start_q, tx_start_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_src_q, tx_src_d;
   logic          ovf_a_q, ovf_b_q, ack_err_q, idle_q;
   logic          ack_set, grant, pick_b;

   logic [7:0]    head_a, head_b;
   logic [CW-1:0] cnt_a_q, cnt_b_q, cnt_a_nxt, cnt_b_nxt;
   logic          drop_a, drop_b;

   serial_tx_arbiter_fifo #(.DEPTH(DEPTH)) u_fifo_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_i    (wr_a),
      .din_i     (din_a),
      .pop_i     (grant && !pick_b),
      .head_o    (head_a),
      .cnt_o     (cnt_a_q),
      .cnt_nxt_o (cnt_a_nxt),
      .drop_o    (drop_a)
   );

   serial_tx_arbiter_fifo #(.DEPTH(DEPTH)) u_fifo_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_i    (wr_b),
      .din_i     (din_b),
      .pop_i     (grant && pick_b),
      .head_o    (head_b),
      .cnt_o     (cnt_b_q),
      .cnt_nxt_o (cnt_b_nxt),
      .drop_o    (drop_b)
   );

   always_comb begin
      state_d    = state_q;
      tmr_d      = tmr_q;
      last_b_d   = last_b_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      tx_src_d   = tx_src_q;
      ack_set    = 1'b0;
      grant      = 1'b0;
      pick_b     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if ((cnt_a_q != '0) || (cnt_b_q != '0)) begin
               grant      = 1'b1;
               // B wins only when A is empty or A had the last grant
               pick_b     = (cnt_b_q != '0) && ((cnt_a_q == '0) || !last_b_q);
               tx_data_d  = pick_b ? head_b : head_a;
               tx_src_d   = pick_b;
               last_b_d   = pick_b;
               tx_start_d = 1'b1;
               state_d    = S_START;
            end
         end
         S_START: begin
            tmr_d   = ACK_LOAD;
            state_d = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (tx_busy) begin
               state_d = S_WAIT_DONE;
            end else if (tmr_q == '0) begin
               ack_set = 1'b1;
               tmr_d   = GAP_LOAD;
               state_d = S_GAP;
            end else begin
               tmr_d = tmr_q - TMR_ONE;
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy) begin
               tmr_d   = GAP_LOAD;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (tmr_q == '0) state_d = S_IDLE;
            else             tmr_d   = tmr_q - TMR_ONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         tmr_q      <= '0;
         last_b_q   <= 1'b1;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         tx_src_q   <= 1'b0;
         ovf_a_q    <= 1'b0;
         ovf_b_q    <= 1'b0;
         ack_err_q  <= 1'b0;
         idle_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         last_b_q   <= last_b_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         tx_src_q   <= tx_src_d;
         // a set in the same cycle as the clear wins
         ovf_a_q    <= (ovf_a_q   && !clr_ovf) || drop_a;
         ovf_b_q    <= (ovf_b_q   && !clr_ovf) || drop_b;
         ack_err_q  <= (ack_err_q && !clr_ovf) || ack_set;
         idle_q     <= (state_d == S_IDLE) && (cnt_a_nxt == '0) && (cnt_b_nxt == '0);
      end
   end

   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;
   assign tx_src   = tx_src_q;
   assign cnt_a    = cnt_a_q;
   assign cnt_b    = cnt_b_q;
   assign ovf_a    = ovf_a_q;
   assign ovf_b    = ovf_b_q;
   assign ack_err  = ack_err_q;
   assign idle     = idle_q;
endmodule

// File: tb/tb_serial_tx_arbiter.sv
module tb_serial_tx_arbiter;
   localparam int DEPTH = 4;
   localparam int GAP   = 2;
   localparam int ACK   = 4;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int G1    = (GAP > 0) ? GAP : 1;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          wr_a = 1'b0, wr_b = 1'b0, clr_ovf = 1'b0, tx_busy = 1'b0;
   logic [7:0]    din_a = '0, din_b = '0;
   logic          tx_start, tx_src, ovf_a, ovf_b, ack_err, idle;
   logic [7:0]    tx_data;
   logic [CW-1:0] cnt_a, cnt_b;

   always #5 clk = ~clk;

   serial_tx_arbiter #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)) dut (
      .clk(clk), .rst_n(rst_n), .wr_a(wr_a), .din_a(din_a), .wr_b(wr_b), .din_b(din_b),
      .clr_ovf(clr_ovf), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
      .tx_src(tx_src), .cnt_a(cnt_a), .cnt_b(cnt_b), .ovf_a(ovf_a), .ovf_b(ovf_b),
      .ack_err(ack_err), .idle(idle)
   );

   int checks = 0, errors = 0, cyc = 0;
   int xm = 3;            // transmitter model: 0 respond, 1 silent, 2 hold busy, 3 manual
   int bs = 0, be = 0, len = 3;
   logic [7:0] log_d[$];
   logic       log_s[$];

   typedef struct {
      logic wa; logic [7:0] da; logic wb; logic [7:0] db; logic busy;
      logic e_start; logic [7:0] e_data; logic e_src;
      logic [CW-1:0] e_ca; logic [CW-1:0] e_cb; logic e_idle;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t mk(input int wa, input int da, input int wb, input int db,
                               input int busy, input int st, input int dat, input int src,
                               input int ca, input int cb, input int idl);
      vec_t v;
      v.wa = wa[0]; v.da = da[7:0]; v.wb = wb[0]; v.db = db[7:0]; v.busy = busy[0];
      v.e_start = st[0]; v.e_data = dat[7:0]; v.e_src = src[0];
      v.e_ca = ca[CW-1:0]; v.e_cb = cb[CW-1:0]; v.e_idle = idl[0];
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
      cyc++;
      wr_a = 1'b0; wr_b = 1'b0; clr_ovf = 1'b0;
      if (tx_start === 1'b1) begin
         log_d.push_back(tx_data);
         log_s.push_back(tx_src);
         bs = cyc + 1;
         be = cyc + 1 + len;
      end
      case (xm)
         0: tx_busy = (cyc >= bs) && (cyc < be);
         1: tx_busy = 1'b0;
         2: tx_busy = 1'b1;
         default: ;
      endcase
   endtask

   task automatic do_reset();
      rst_n = 1'b0; wr_a = 1'b0; wr_b = 1'b0; clr_ovf = 1'b0; tx_busy = 1'b0; xm = 3;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      log_d.delete(); log_s.delete();
   endtask

   task automatic wait_starts(input int n, input int budget, input string nm);
      int k = 0;
      while (log_d.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk(nm, log_d.size(), n);
   endtask

   // random-test reference model state
   logic [7:0] qa[$], qb[$];
   logic       m_last_b, m_ovf_a, m_ovf_b, m_ack, e_start, e_src;
   logic [7:0] e_data;
   int         idle_from, ack_at, rb_on, rb_off;

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset values ----
      do_reset();
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_tx_src", tx_src, 0);
      chk("rst_cnt_a", cnt_a, 0);
      chk("rst_cnt_b", cnt_b, 0);
      chk("rst_flags", {ovf_a, ovf_b, ack_err}, 0);
      chk("rst_idle", idle, 1);

      // ---- table: single A frame with 1-cycle ack, 10-cycle busy, then a B byte ----
      tbl.push_back(mk(1, 8'h41, 0, 0, 0,  0, 8'h00, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0,      1, 8'h41, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0,      0, 8'h41, 0, 0, 0, 0));
      for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 0, 0, 0, 1, 0, 8'h41, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0,      0, 8'h41, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0,      0, 8'h41, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0,      0, 8'h41, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 1, 8'h55, 0,  0, 8'h41, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0,      1, 8'h55, 1, 0, 0, 0));
      for (int i = 0; i < tbl.size(); i++) begin
         wr_a = tbl[i].wa; din_a = tbl[i].da; wr_b = tbl[i].wb; din_b = tbl[i].db;
         tx_busy = tbl[i].busy;
         tick();
         chk($sformatf("tbl%0d_start", i), tx_start, tbl[i].e_start);
         chk($sformatf("tbl%0d_data", i), tx_data, tbl[i].e_data);
         chk($sformatf("tbl%0d_src", i), tx_src, tbl[i].e_src);
         chk($sformatf("tbl%0d_cnt_a", i), cnt_a, tbl[i].e_ca);
         chk($sformatf("tbl%0d_cnt_b", i), cnt_b, tbl[i].e_cb);
         chk($sformatf("tbl%0d_idle", i), idle, tbl[i].e_idle);
      end

      // ---- round-robin order after preloading while busy ----
      do_reset();
      xm = 2; tx_busy = 1'b1;
      wr_a = 1'b1; din_a = 8'h31; tick();
      wr_b = 1'b1; din_b = 8'hA0; tick();
      wr_a = 1'b1; din_a = 8'h32; tick();
      wr_b = 1'b1; din_b = 8'hA1; tick();
      repeat (3) tick();
      xm = 0; len = 3;
      wait_starts(4, 100, "rr_count");
      begin
         logic [7:0] exp_d [4];
         exp_d[0] = 8'h31; exp_d[1] = 8'hA0; exp_d[2] = 8'h32; exp_d[3] = 8'hA1;
         for (int i = 0; i < 4 && i < log_d.size(); i++) begin
            chk($sformatf("rr_data%0d", i), log_d[i], exp_d[i]);
            chk($sformatf("rr_src%0d", i), log_s[i], i % 2);
         end
      end

      // ---- overflow of FIFO A while a frame holds the transmitter ----
      do_reset();
      xm = 2; tx_busy = 1'b1;
      wr_b = 1'b1; din_b = 8'h77; tick();
      repeat (3) tick();
      for (int i = 0; i < 5; i++) begin
         wr_a = 1'b1; din_a = 8'hD0 + 8'(i); tick();
         if (i == 3) begin
            chk("ovf_cnt_at4", cnt_a, 4);
            chk("ovf_flag_at4", ovf_a, 0);
         end
      end
      chk("ovf_cnt_at5", cnt_a, 4);
      chk("ovf_flag_at5", ovf_a, 1);
      chk("ovf_b_clean", ovf_b, 0);
      clr_ovf = 1'b1; tick();
      chk("ovf_cleared", ovf_a, 0);
      log_d.delete(); log_s.delete();
      xm = 0;
      wait_starts(4, 120, "ovf_drain_count");
      for (int i = 0; i < 4 && i < log_d.size(); i++)
         chk($sformatf("ovf_drain%0d", i), log_d[i], 8'hD0 + 8'(i));

      // ---- ack timeout ----
      do_reset();
      xm = 1;
      wr_a = 1'b1; din_a = 8'h10; tick();
      wr_a = 1'b1; din_a = 8'h11; tick();
      chk("ack_first_start", log_d.size(), 1);
      for (int k = 1; k <= ACK + 1; k++) begin
         tick();
         chk($sformatf("ack_err_k%0d", k), ack_err, (k == ACK + 1));
      end
      log_d.delete(); log_s.delete();
      xm = 0;
      wait_starts(1, 40, "ack_next_count");
      if (log_d.size() > 0) begin
         chk("ack_next_data", log_d[0], 8'h11);
         chk("ack_next_src", log_s[0], 0);
      end
      chk("ack_sticky", ack_err, 1);
      clr_ovf = 1'b1; tick();
      chk("ack_cleared", ack_err, 0);

      // ---- full FIFO B, push in the same cycle as the grant pop ----
      do_reset();
      xm = 2; tx_busy = 1'b1;
      wr_a = 1'b1; din_a = 8'h01; tick();
      repeat (3) tick();
      for (int i = 0; i < 4; i++) begin
         wr_b = 1'b1; din_b = 8'hB0 + 8'(i); tick();
      end
      chk("full_b_cnt", cnt_b, 4);
      xm = 3; tx_busy = 1'b0;
      repeat (3) tick();
      chk("full_b_pre_grant", cnt_b, 4);
      log_d.delete(); log_s.delete();
      wr_b = 1'b1; din_b = 8'hB4; tick();
      chk("full_b_start", tx_start, 1);
      chk("full_b_data", tx_data, 8'hB0);
      chk("full_b_src", tx_src, 1);
      chk("full_b_cnt_after", cnt_b, 4);
      chk("full_b_ovf", ovf_b, 0);
      xm = 0;
      wait_starts(5, 150, "full_b_count");
      for (int i = 0; i < 5 && i < log_d.size(); i++)
         chk($sformatf("full_b_order%0d", i), log_d[i], 8'hB0 + 8'(i));

      // ---- asynchronous reset in WAIT_DONE with bytes queued ----
      do_reset();
      xm = 2; tx_busy = 1'b1;
      wr_a = 1'b1; din_a = 8'h61; tick();
      repeat (3) tick();
      wr_a = 1'b1; din_a = 8'h62; wr_b = 1'b1; din_b = 8'h64; tick();
      wr_a = 1'b1; din_a = 8'h63; tick();
      chk("mid_pre_cnt_a", cnt_a, 2);
      chk("mid_pre_data", tx_data, 8'h61);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_start", tx_start, 0);
      chk("mid_rst_data", tx_data, 0);
      chk("mid_rst_src", tx_src, 0);
      chk("mid_rst_cnt", {cnt_a, cnt_b}, 0);
      chk("mid_rst_flags", {ovf_a, ovf_b, ack_err}, 0);
      chk("mid_rst_idle", idle, 1);
      xm = 1; tx_busy = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      log_d.delete(); log_s.delete();
      repeat (20) tick();
      chk("mid_no_start", log_d.size(), 0);
      chk("mid_idle", idle, 1);
      wr_a = 1'b1; din_a = 8'h70; tick();
      tick();
      chk("mid_new_start", tx_start, 1);
      chk("mid_new_data", tx_data, 8'h70);

      // ---- randomized traffic against the reference model ----
      do_reset();
      qa.delete(); qb.delete();
      m_last_b = 1'b1; m_ovf_a = 1'b0; m_ovf_b = 1'b0; m_ack = 1'b0;
      e_start = 1'b0; e_src = 1'b0; e_data = 8'h00;
      idle_from = 0; ack_at = -100; rb_on = 0; rb_off = 0;
      for (int c = 0; c < 3000 && errors < 40; c++) begin
         logic wa, wb, clr, drop_a, drop_b, nxt_start, pb;
         logic [7:0] da, db;
         chk("rnd_start", tx_start, e_start);
         chk("rnd_data", tx_data, e_data);
         chk("rnd_src", tx_src, e_src);
         chk("rnd_cnt_a", cnt_a, qa.size());
         chk("rnd_cnt_b", cnt_b, qb.size());
         chk("rnd_ovf", {ovf_a, ovf_b}, {m_ovf_a, m_ovf_b});
         chk("rnd_ack", ack_err, m_ack);
         chk("rnd_idle", idle, (c >= idle_from) && qa.size() == 0 && qb.size() == 0);

         wa = ($urandom_range(0, 9) < 4); da = 8'($urandom);
         wb = ($urandom_range(0, 9) < 4); db = 8'($urandom);
         clr = ($urandom_range(0, 19) == 0);
         wr_a = wa; din_a = da; wr_b = wb; din_b = db; clr_ovf = clr;
         tx_busy = (c >= rb_on) && (c < rb_off);

         nxt_start = 1'b0; drop_a = 1'b0; drop_b = 1'b0;
         if (c >= idle_from && (qa.size() > 0 || qb.size() > 0)) begin
            int s, d, l;
            pb = (qb.size() > 0) && (qa.size() == 0 || !m_last_b);
            if (pb) e_data = qb.pop_front(); else e_data = qa.pop_front();
            e_src = pb; m_last_b = pb; nxt_start = 1'b1;
            s = c + 1;
            d = $urandom_range(0, 3);
            l = $urandom_range(1, 5);
            if (d == 0) begin
               rb_on = 0; rb_off = 0;
               ack_at = s + 1 + ACK;
               idle_from = s + 1 + ACK + G1;
            end else begin
               rb_on = s + d; rb_off = s + d + l;
               idle_from = s + d + l + 1 + G1;
            end
         end
         if (wa) begin
            if (qa.size() < DEPTH) qa.push_back(da); else drop_a = 1'b1;
         end
         if (wb) begin
            if (qb.size() < DEPTH) qb.push_back(db); else drop_b = 1'b1;
         end
         m_ovf_a = (m_ovf_a && !clr) || drop_a;
         m_ovf_b = (m_ovf_b && !clr) || drop_b;
         m_ack   = (m_ack && !clr) || (c + 1 == ack_at);
         e_start = nxt_start;
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
- Shares the single serial transmitter between two byte producers.
  - Port A: keyboard ASCII bytes (key-press events).
  - Port B: echo/loopback bytes from the serial receiver path.
- Each port has a small FIFO; a round-robin scheduler pops one byte at a time.
- Drives the transmitter's one-cycle start strobe and tracks its busy handshake.
- Sits between the keyboard/receiver front ends and the serial sender, all in the module-clock (clk_m) domain.

Parameters:
- DEPTH, 4, entries per requester FIFO (power of two, 2..16).
- GAP_CYCLES, 2, idle cycles inserted after each frame completes before the next grant.
- ACK_TIMEOUT, 4, cycles allowed after tx_start for tx_busy to rise before the frame is abandoned.

Ports:
- clk  in  1  module clock (clk_m); all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_a  in  1  one-cycle push strobe, requester A.
- din_a  in  8  byte for requester A, sampled when wr_a=1.
- wr_b  in  1  one-cycle push strobe, requester B.
- din_b  in  8  byte for requester B, sampled when wr_b=1.
- clr_ovf  in  1  synchronous clear of ovf_a, ovf_b, ack_err.
- tx_busy  in  1  transmitter busy; high for the duration of a frame.
- tx_start  out  1  one-cycle start strobe to the transmitter.
- tx_data  out  8  byte being sent; stable from tx_start until the arbiter returns to IDLE.
- tx_src  out  1  source of the current byte: 0=A, 1=B.
- cnt_a  out  $clog2(DEPTH)+1  FIFO A occupancy.
- cnt_b  out  $clog2(DEPTH)+1  FIFO B occupancy.
- ovf_a  out  1  sticky: a push to full FIFO A was dropped.
- ovf_b  out  1  sticky: a push to full FIFO B was dropped.
- ack_err  out  1  sticky: tx_busy failed to rise within ACK_TIMEOUT.
- idle  out  1  high when in IDLE and both FIFOs are empty.

Behaviour:
- Reset values (async, on rst_n low): tx_start=0, tx_data=0, tx_src=0, cnt_a=cnt_b=0, ovf_a=ovf_b=ack_err=0, idle=1, state=IDLE, last_grant=B (so A wins the first tie). FIFO pointers return to 0.
- Reset mid-frame aborts the frame. FIFO contents are discarded; the transmitter is not signalled.
- FIFO push: on wr_x=1 with cnt_x<DEPTH, din_x is written and cnt_x increments next cycle.
- Push to a full FIFO: byte dropped, cnt_x unchanged, ovf_x set next cycle.
- Push and pop on the same FIFO in the same cycle:
  - Both succeed, cnt unchanged, including when the FIFO is full.
  - On an empty FIFO no pop can occur, so the push alone applies.
- Pointers wrap modulo DEPTH.
- Sticky flags: clr_ovf=1 clears all three next cycle. A set condition in the same cycle as clr_ovf wins (flag stays 1).
- State machine, one transition per clk:
  - IDLE: if either FIFO is non-empty, grant per round-robin:
    - only A non-empty → A; only B non-empty → B;
    - both non-empty → the requester not equal to last_grant.
    - Registered on the grant cycle: pop head into tx_data, set tx_src, update last_grant, tx_start=1 next cycle, go START.
  - START: tx_start=1 for exactly this cycle; reset timeout counter; go WAIT_ACK.
  - WAIT_ACK: if tx_busy=1, go WAIT_DONE. Otherwise increment the counter; after ACK_TIMEOUT cycles without busy, set ack_err and go GAP (byte lost, not retried).
  - WAIT_DONE: stay while tx_busy=1; on tx_busy=0 go GAP.
  - GAP: count GAP_CYCLES cycles, then go IDLE. GAP_CYCLES=0 means direct to IDLE on the following cycle.
- Latency: a push into an empty FIFO while IDLE (other FIFO empty) gives tx_start high 2 cycles after the wr strobe cycle. The sequence is push cycle → grant cycle → START.
- Pushes are accepted in all states; FIFOs are never stalled by the scheduler.
- tx_busy already high in START (transmitter still busy from an external source): WAIT_ACK sees it immediately and proceeds to WAIT_DONE.
- tx_start never asserts outside START; never two strobes without an intervening tx_busy low.
- idle = (state==IDLE) && cnt_a==0 && cnt_b==0, registered.

Test Plan:
- Reset, push A=8'h41 once, transmitter model raises busy 1 cycle after start for 10 cycles → tx_start 2 cycles after wr_a, tx_data=8'h41, tx_src=0; idle=1 after GAP.
- Preload A with 8'h31,8'h32 and B with 8'hA0,8'hA1 while busy is held high, then release → send order 31,A0,32,A1 with alternating tx_src starting at 0.
- Push 5 bytes to A in consecutive cycles with DEPTH=4 while a frame is in progress → cnt_a=4, 5th byte dropped, ovf_a=1; clr_ovf → ovf_a=0 next cycle.
- Transmitter model never raises busy → ack_err=1 exactly ACK_TIMEOUT cycles after WAIT_ACK entry; next queued byte is still sent afterwards.
- FIFO B full, simultaneous wr_b with a grant pop from B → cnt_b stays 4, ovf_b stays 0; popped and pushed bytes appear in FIFO order.
- Assert rst_n low during WAIT_DONE with 3 bytes queued → all outputs at reset values asynchronously; no tx_start after release until a new push.
